// File: rtl/rcv_pkt_forwarder.sv
// Buffers Rcv packets in a byte RAM, rolls back dropped ones, and replays committed packets with sop/eop/ctrl/seq.
// First tx_valid 3 cycles after a committing close; holds all tx outputs while tx_valid & !tx_ready.
module rcv_pkt_forwarder #(
  parameter int DATA_AW = 11,
  parameter int DESC_AW = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [7:0]       data_in,
  input  logic             data_valid_in,
  input  logic [23:0]      ctrl_in,
  input  logic             ctrl_valid_in,
  input  logic             discard_in,
  input  logic [14:0]      seq_num_in,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             tx_sop,
  output logic             tx_eop,
  output logic [23:0]      tx_ctrl,
  output logic [14:0]      tx_seq,
  input  logic             tx_ready,
  output logic [CNT_W-1:0] pkt_fwd_cnt,
  output logic [CNT_W-1:0] pkt_drop_cnt
);
  localparam int LEN_W = 11;
  localparam logic [DESC_AW:0] DESC_DEPTH = {1'b1, {DESC_AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  typedef struct packed {
    logic [DATA_AW-1:0] start;
    logic [LEN_W-1:0]   len;
    logic [23:0]        ctrl;
    logic [14:0]        seq;
  } desc_t;

  logic [7:0] buf_mem  [0:(1<<DATA_AW)-1];
  desc_t      desc_mem [0:(1<<DESC_AW)-1];

  logic [DATA_AW-1:0] wr_ptr_q, wr_ptr_d, pkt_start_q, pkt_start_d;
  logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic               ovf_q, ovf_d;
  logic [DESC_AW:0]   desc_wr_q, desc_wr_d, desc_rd_q, desc_rd_d, desc_cnt_q, desc_cnt_d;
  logic [CNT_W-1:0]   fwd_cnt_q, fwd_cnt_d, drop_cnt_q, drop_cnt_d;

  state_t             state_q, state_d;
  logic [DATA_AW-1:0] rd_ptr_q, rd_ptr_d, rd_addr;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               rd_en;
  logic               tx_valid_q, tx_valid_d, tx_sop_q, tx_sop_d, tx_eop_q, tx_eop_d;
  logic [7:0]         tx_data_q;
  logic [23:0]        tx_ctrl_q, tx_ctrl_d;
  logic [14:0]        tx_seq_q, tx_seq_d;

  logic               buf_full, byte_wr, ovf_eff, pkt_bad, commit, drop;
  logic               desc_empty, desc_full, accept, pkt_done;
  logic [LEN_W-1:0]   cnt_eff;
  logic [DATA_AW-1:0] wr_ptr_eff;
  desc_t              head;

  assign accept     = tx_valid_q && tx_ready;
  assign pkt_done   = accept && tx_eop_q;
  assign desc_empty = (desc_wr_q == desc_rd_q);
  // A slot stays reserved until its packet's eop is accepted, so the packet on the wire counts as occupancy.
  assign desc_full  = (desc_cnt_q == DESC_DEPTH);
  assign head       = desc_mem[desc_rd_q[DESC_AW-1:0]];

  always_comb begin
    buf_full   = ((wr_ptr_q + DATA_AW'(1)) == rd_ptr_q);
    byte_wr    = data_valid_in && !buf_full;
    wr_ptr_eff = byte_wr ? wr_ptr_q + DATA_AW'(1) : wr_ptr_q;
    cnt_eff    = byte_cnt_q;
    if (data_valid_in && (byte_cnt_q != '1)) cnt_eff = byte_cnt_q + LEN_W'(1);
    ovf_eff    = ovf_q || (data_valid_in && buf_full);
    pkt_bad    = discard_in || ovf_eff || (cnt_eff == '0) ||
                 (cnt_eff != ctrl_in[LEN_W-1:0]) || desc_full;
    commit     = ctrl_valid_in && !pkt_bad;
    drop       = ctrl_valid_in && pkt_bad;

    wr_ptr_d    = wr_ptr_eff;
    pkt_start_d = pkt_start_q;
    byte_cnt_d  = cnt_eff;
    ovf_d       = ovf_eff;
    desc_wr_d   = desc_wr_q;
    fwd_cnt_d   = fwd_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    desc_cnt_d  = desc_cnt_q;

    if (ctrl_valid_in) begin
      byte_cnt_d = '0;
      ovf_d      = 1'b0;
    end
    if (commit) begin
      pkt_start_d = wr_ptr_eff;
      desc_wr_d   = desc_wr_q + 1'b1;
      if (fwd_cnt_q != '1) fwd_cnt_d = fwd_cnt_q + 1'b1;
    end
    if (drop) begin
      wr_ptr_d = pkt_start_q;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end
    case ({commit, pkt_done})
      2'b10:   desc_cnt_d = desc_cnt_q + 1'b1;
      2'b01:   desc_cnt_d = desc_cnt_q - 1'b1;
      default: desc_cnt_d = desc_cnt_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    rem_d      = rem_q;
    desc_rd_d  = desc_rd_q;
    tx_valid_d = tx_valid_q;
    tx_sop_d   = tx_sop_q;
    tx_eop_d   = tx_eop_q;
    tx_ctrl_d  = tx_ctrl_q;
    tx_seq_d   = tx_seq_q;
    rd_addr    = rd_ptr_q;
    rd_en      = 1'b0;
    case (state_q)
      IDLE: if (!desc_empty) state_d = LOAD;
      LOAD: begin
        desc_rd_d  = desc_rd_q + 1'b1;
        tx_ctrl_d  = head.ctrl;
        tx_seq_d   = head.seq;
        rd_ptr_d   = head.start;
        rem_d      = head.len;
        rd_addr    = head.start;
        rd_en      = 1'b1;
        tx_valid_d = 1'b1;
        tx_sop_d   = 1'b1;
        tx_eop_d   = (head.len == LEN_W'(1));
        state_d    = SEND;
      end
      SEND: if (accept) begin
        rd_ptr_d = rd_ptr_q + DATA_AW'(1);
        rem_d    = rem_q - LEN_W'(1);
        if (tx_eop_q) begin
          tx_valid_d = 1'b0;
          tx_sop_d   = 1'b0;
          tx_eop_d   = 1'b0;
          state_d    = desc_empty ? IDLE : LOAD;
        end else begin
          rd_addr  = rd_ptr_q + DATA_AW'(1);
          rd_en    = 1'b1;
          tx_sop_d = 1'b0;
          tx_eop_d = (rem_q == LEN_W'(2));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (byte_wr) buf_mem[wr_ptr_q] <= data_in;
    if (commit) desc_mem[desc_wr_q[DESC_AW-1:0]] <= '{start: pkt_start_q, len: cnt_eff,
                                                       ctrl: ctrl_in, seq: seq_num_in};
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      pkt_start_q <= '0;
      byte_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      desc_wr_q   <= '0;
      desc_rd_q   <= '0;
      desc_cnt_q  <= '0;
      fwd_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      rem_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_sop_q    <= 1'b0;
      tx_eop_q    <= 1'b0;
      tx_data_q   <= '0;
      tx_ctrl_q   <= '0;
      tx_seq_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      pkt_start_q <= pkt_start_d;
      byte_cnt_q  <= byte_cnt_d;
      ovf_q       <= ovf_d;
      desc_wr_q   <= desc_wr_d;
      desc_rd_q   <= desc_rd_d;
      desc_cnt_q  <= desc_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      rem_q       <= rem_d;
      tx_valid_q  <= tx_valid_d;
      tx_sop_q    <= tx_sop_d;
      tx_eop_q    <= tx_eop_d;
      if (rd_en) tx_data_q <= buf_mem[rd_addr];
      tx_ctrl_q   <= tx_ctrl_d;
      tx_seq_q    <= tx_seq_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign tx_sop       = tx_sop_q;
  assign tx_eop       = tx_eop_q;
  assign tx_ctrl      = tx_ctrl_q;
  assign tx_seq       = tx_seq_q;
  assign pkt_fwd_cnt  = fwd_cnt_q;
  assign pkt_drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_rcv_pkt_forwarder.sv
// Directed bench for rcv_pkt_forwarder with a beat-level scoreboard fed at packet-send time.
module tb_rcv_pkt_forwarder;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        data_valid_in;
  logic [23:0] ctrl_in;
  logic        ctrl_valid_in;
  logic        discard_in;
  logic [14:0] seq_num_in;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_sop, tx_eop;
  logic [23:0] tx_ctrl;
  logic [14:0] tx_seq;
  logic        tx_ready;
  logic [15:0] pkt_fwd_cnt, pkt_drop_cnt;

  rcv_pkt_forwarder dut (
    .clk_sys(clk_sys), .reset(reset), .data_in(data_in), .data_valid_in(data_valid_in),
    .ctrl_in(ctrl_in), .ctrl_valid_in(ctrl_valid_in), .discard_in(discard_in),
    .seq_num_in(seq_num_in), .tx_data(tx_data), .tx_valid(tx_valid), .tx_sop(tx_sop),
    .tx_eop(tx_eop), .tx_ctrl(tx_ctrl), .tx_seq(tx_seq), .tx_ready(tx_ready),
    .pkt_fwd_cnt(pkt_fwd_cnt), .pkt_drop_cnt(pkt_drop_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [7:0]  d;
    logic        sop;
    logic        eop;
    logic [23:0] ctrl;
    logic [14:0] seq;
  } beat_t;

  beat_t exp_q[$];
  int    vectors = 0, miscompares = 0;
  int    exp_fwd = 0, exp_drop = 0;
  int    cyc = 0, sop_cyc = 0, eop_cyc = -100, last_gap = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop on each accepted beat, hold check after each stalled cycle.
  beat_t obs_b, held_b, exp_b;
  logic  stall_q = 1'b0;
  always @(negedge clk_sys) begin
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      obs_b = {tx_data, tx_sop, tx_eop, tx_ctrl, tx_seq};
      if (stall_q) check("hold_while_stalled", 64'({tx_valid, obs_b}), 64'({1'b1, held_b}));
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat_queue_size", 64'(exp_q.size()), 64'd1);
        end else begin
          exp_b = exp_q.pop_front();
          check("beat", 64'(obs_b), 64'(exp_b));
          if (tx_sop) begin
            last_gap = cyc - eop_cyc;
            sop_cyc  = cyc;
          end
          if (tx_eop) eop_cyc = cyc;
        end
      end
      stall_q = tx_valid && !tx_ready;
      held_b  = obs_b;
    end
  end

  task automatic send_pkt(input int n, input logic [7:0] base, input logic [10:0] len,
                          input logic [12:0] tag, input logic [14:0] seq,
                          input logic disc, input logic same, input logic ok);
    for (int i = 0; i < n; i++) begin
      data_in       = 8'(base + i);
      data_valid_in = 1'b1;
      if (same && i == n - 1) begin
        ctrl_valid_in = 1'b1;
        ctrl_in       = {tag, len};
        discard_in    = disc;
        seq_num_in    = seq;
      end
      if (ok) exp_q.push_back('{8'(base + i), i == 0, i == n - 1, {tag, len}, seq});
      @(posedge clk_sys); #1;
    end
    data_valid_in = 1'b0;
    ctrl_valid_in = 1'b0;
    if (!same || n == 0) begin
      ctrl_valid_in = 1'b1;
      ctrl_in       = {tag, len};
      discard_in    = disc;
      seq_num_in    = seq;
      @(posedge clk_sys); #1;
      ctrl_valid_in = 1'b0;
    end
    discard_in = 1'b0;
    if (ok) exp_fwd++;
    else    exp_drop++;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk_sys);
      k++;
    end
    repeat (3) @(negedge clk_sys);
    check({tag, "_beats_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_idle_valid"}, 64'(tx_valid), 64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; data_in = '0; data_valid_in = 1'b0; ctrl_in = '0; ctrl_valid_in = 1'b0;
    discard_in = 1'b0; seq_num_in = '0; tx_ready = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_sop", 64'(tx_sop), 64'd0);
    check("rst_tx_eop", 64'(tx_eop), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_tx_ctrl", 64'(tx_ctrl), 64'd0);
    check("rst_tx_seq", 64'(tx_seq), 64'd0);
    check("rst_fwd_cnt", 64'(pkt_fwd_cnt), 64'd0);
    check("rst_drop_cnt", 64'(pkt_drop_cnt), 64'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Single 64-byte packet: latency, framing and throughput.
    send_pkt(64, 8'h00, 11'd64, 13'd0, 15'd5, 1'b0, 1'b0, 1'b1);
    @(negedge clk_sys); check("lat_cycle1_valid", 64'(tx_valid), 64'd0);
    @(negedge clk_sys); check("lat_cycle2_valid", 64'(tx_valid), 64'd0);
    @(negedge clk_sys); check("lat_cycle3_valid", 64'(tx_valid), 64'd1);
    check("first_sop", 64'(tx_sop), 64'd1);
    check("first_data", 64'(tx_data), 64'h00);
    check("first_seq", 64'(tx_seq), 64'd5);
    wait_drain("single", 200);
    check("single_back_to_back", 64'(eop_cyc - sop_cyc), 64'd63);
    check("single_fwd_cnt", 64'(pkt_fwd_cnt), 64'(exp_fwd));

    // Discarded packet followed by a good one reusing the rolled-back space.
    send_pkt(100, 8'h80, 11'd100, 13'd1, 15'd6, 1'b1, 1'b0, 1'b0);
    send_pkt(20, 8'h40, 11'd20, 13'd2, 15'd7, 1'b0, 1'b0, 1'b1);
    wait_drain("discard", 200);
    check("discard_drop_cnt", 64'(pkt_drop_cnt), 64'(exp_drop));
    check("discard_fwd_cnt", 64'(pkt_fwd_cnt), 64'(exp_fwd));

    // Length mismatch and empty packet.
    send_pkt(30, 8'h10, 11'd31, 13'd3, 15'd8, 1'b0, 1'b0, 1'b0);
    send_pkt(0, 8'h00, 11'd0, 13'd4, 15'd9, 1'b0, 1'b0, 1'b0);
    repeat (6) @(negedge clk_sys);
    check("mismatch_no_valid", 64'(tx_valid), 64'd0);
    check("mismatch_drop_cnt", 64'(pkt_drop_cnt), 64'(exp_drop));

    // 512-byte packet under alternating backpressure.
    send_pkt(512, 8'h20, 11'd512, 13'd5, 15'd10, 1'b0, 1'b0, 1'b1);
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      tx_ready = ~tx_ready;
      @(posedge clk_sys); #1;
      k++;
    end
    tx_ready = 1'b1;
    wait_drain("backpressure", 10);
    check("backpressure_fwd_cnt", 64'(pkt_fwd_cnt), 64'(exp_fwd));

    // Nine packets closed on their last byte while stalled: descriptor FIFO holds eight.
    tx_ready = 1'b0;
    for (int p = 0; p < 9; p++)
      send_pkt(80, 8'(p * 16), 11'd80, 13'(p + 8), 15'(20 + p), 1'b0, 1'b1, p < 8);
    check("descfull_fwd_cnt", 64'(pkt_fwd_cnt), 64'(exp_fwd));
    check("descfull_drop_cnt", 64'(pkt_drop_cnt), 64'(exp_drop));
    tx_ready = 1'b1;
    wait_drain("descfull", 2000);
    check("interpacket_gap", 64'(last_gap), 64'd2);

    // Three 700-byte packets while stalled: the third overflows, the second wraps the buffer.
    tx_ready = 1'b0;
    send_pkt(700, 8'h11, 11'd700, 13'd30, 15'd40, 1'b0, 1'b0, 1'b1);
    send_pkt(700, 8'h22, 11'd700, 13'd31, 15'd41, 1'b0, 1'b1, 1'b1);
    send_pkt(700, 8'h33, 11'd700, 13'd32, 15'd42, 1'b0, 1'b0, 1'b0);
    check("overflow_drop_cnt", 64'(pkt_drop_cnt), 64'(exp_drop));
    tx_ready = 1'b1;
    wait_drain("overflow", 3000);
    check("overflow_fwd_cnt", 64'(pkt_fwd_cnt), 64'(exp_fwd));

    // Reset in the middle of a transmission, then recovery.
    send_pkt(40, 8'h50, 11'd40, 13'd50, 15'd60, 1'b0, 1'b0, 1'b1);
    k = 0;
    while (!tx_valid && k < 20) begin
      @(negedge clk_sys);
      k++;
    end
    check("midreset_started", 64'(tx_valid), 64'd1);
    repeat (5) @(posedge clk_sys);
    #1;
    reset = 1'b1;
    #1;
    check("midreset_valid", 64'(tx_valid), 64'd0);
    check("midreset_fwd_cnt", 64'(pkt_fwd_cnt), 64'd0);
    exp_q.delete();
    exp_fwd  = 0;
    exp_drop = 0;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    @(negedge clk_sys);
    send_pkt(10, 8'h60, 11'd10, 13'd51, 15'd61, 1'b0, 1'b1, 1'b1);
    wait_drain("post_reset", 100);
    check("post_reset_fwd_cnt", 64'(pkt_fwd_cnt), 64'(exp_fwd));
    check("post_reset_drop_cnt", 64'(pkt_drop_cnt), 64'(exp_drop));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rcv_pkt_forwarder.md
Name: rcv_pkt_forwarder

Overview:
Downstream stage of the receive subsystem on the system clock. It consumes Rcv's byte stream and end-of-packet control word and buffers each packet. Packets that are discarded, length-mismatched or overflowed are rolled back. Committed packets are replayed to the switch fabric over a ready/valid interface with sop/eop framing, sequence number and control word attached.

Parameters:
DATA_AW, 11, log2 of data buffer depth in bytes (2048)
DESC_AW, 3, log2 of descriptor FIFO depth (8 packets)
CNT_W, 16, width of forwarded/dropped packet counters

Ports:
clk_sys  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  8  payload byte from Rcv
data_valid_in  input  1  data_in valid this cycle
ctrl_in  input  24  end-of-packet control word; [10:0] = byte length, [23:11] = opaque tag
ctrl_valid_in  input  1  one-cycle pulse that closes the current packet
discard_in  input  1  sampled with ctrl_valid_in; 1 = drop packet
seq_num_in  input  15  sampled with ctrl_valid_in
tx_data  output  8  outgoing byte
tx_valid  output  1  tx_data/tx_sop/tx_eop valid
tx_sop  output  1  first byte of packet
tx_eop  output  1  last byte of packet
tx_ctrl  output  24  control word of current packet, stable sop..eop
tx_seq  output  15  sequence number of current packet, stable sop..eop
tx_ready  input  1  fabric accepts byte when tx_valid & tx_ready
pkt_fwd_cnt  output  CNT_W  saturating count of committed packets
pkt_drop_cnt  output  CNT_W  saturating count of dropped packets

Behaviour:
- Reset (async): wr_ptr, pkt_start, rd_ptr, byte_cnt and descriptor pointers = 0; overflow flag clear; tx_valid/sop/eop = 0; tx_data/ctrl/seq = 0; counters = 0; FSM = IDLE.
- Write side: each data_valid_in writes data_in at wr_ptr, then wr_ptr++ (mod 2^DATA_AW) and byte_cnt++.
  - Full = wr_ptr+1 == rd_ptr. A byte arriving when full is not written; overflow flag set until packet close.
  - byte_cnt saturates at 2047.
- Packet close on ctrl_valid_in. A data byte in the same cycle belongs to the closing packet and is counted before evaluation. Drop if any of:
  - discard_in = 1
  - overflow flag set
  - byte_cnt == 0
  - byte_cnt != ctrl_in[10:0]
  - descriptor FIFO full
- Drop action: wr_ptr <= pkt_start; pkt_drop_cnt++.
- Commit action: push {pkt_start, byte_cnt, ctrl_in, seq_num_in}; pkt_start <= wr_ptr (incl. same-cycle byte); pkt_fwd_cnt++.
- Either action clears byte_cnt and the overflow flag next cycle.
- Buffer space of dropped bytes is reclaimed immediately. Reader never sees uncommitted bytes; rd_ptr only advances through committed packets.
- Read FSM:
  - IDLE: descriptor FIFO non-empty -> LOAD.
  - LOAD: pop descriptor, latch tx_ctrl/tx_seq, issue first RAM read -> SEND.
  - SEND: tx_valid=1. tx_sop=1 on the first byte. tx_eop=1 when remaining==1.
  - On each tx_valid & tx_ready: rd_ptr++, remaining--. On an accepted eop byte: next descriptor present -> LOAD, else IDLE.
- Read-side outputs are registered. Minimum latency from committing ctrl_valid_in edge to first tx_valid is 3 clk_sys cycles.
- With tx_ready held high, one byte is accepted per cycle within a packet and 1 idle cycle separates packets (LOAD).
- tx_data/sop/eop/ctrl/seq hold while tx_valid & !tx_ready.
- Pointers wrap mod 2^DATA_AW; packets may straddle the wrap point.
- Counters saturate at all-ones, no wrap.
- Reset mid-packet or mid-transmission: everything flushed immediately; tx_valid drops asynchronously.

Test Plan:
- Single packet: 64 bytes 0x00..0x3F, ctrl_in=0x000040, seq=5, tx_ready=1 -> tx_sop with 0x00, tx_eop with 0x3F, 64 beats, tx_seq=5, pkt_fwd_cnt=1.
- Discard: 100 bytes closed with discard_in=1, then 20-byte good packet -> only the 20-byte packet appears; pkt_drop_cnt=1; its first byte is read from the old pkt_start address.
- Length mismatch and empty: 30 bytes with ctrl length 31 -> dropped. ctrl_valid_in with 0 bytes -> dropped. pkt_drop_cnt=2, no tx_valid.
- Backpressure: 512-byte packet, tx_ready toggling 1/0 every cycle -> tx_data stable while stalled, 512 accepted beats in order, eop on 512th.
- Overflow/wrap: tx_ready=0, send 3 x 700-byte packets -> third overflows and is dropped. Release tx_ready -> first two emerge intact; the second straddles address 2047->0.
- Same-cycle close and descriptor full: last byte with ctrl_valid_in -> byte_cnt includes it. Nine packets with tx_ready=0 -> ninth dropped, pkt_fwd_cnt=8.
